// File: rtl/softproc_mem_stream_loader_if.sv
// Byte-stream input and 32-bit memory write bus for the stream loader.
// master is the loader's view, slave is the stream source / memory view.
interface softproc_mem_stream_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        input  in_data, in_valid, in_last,
        output in_ready, mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output in_data, in_valid, in_last,
        input  in_ready, mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/softproc_mem_stream_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to
// on-chip memory from a base address, wrapping at the memory depth.
module softproc_mem_stream_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   words_written,
    softproc_mem_stream_loader_if.master bus
);
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     count_q;
    logic [1:0]        lane;
    logic              last_q;
    logic [CW-1:0]     ww_next_c;
    logic              accept_c;

    assign ww_next_c = words_written + CW'(1);
    assign accept_c  = bus.in_valid && bus.in_ready;

    // Single-process FSM; every output is a flop updated on the transition into its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            base_q             <= '0;
            count_q            <= '0;
            lane               <= '0;
            last_q             <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            words_written      <= '0;
            bus.in_ready       <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_byteenable <= '0;
            bus.mem_chipselect <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_writedata  <= '0;
            bus.mem_clken      <= 1'b1;
        end else begin
            bus.mem_clken <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q             <= base_addr;
                        count_q            <= (word_count == '0) ? CW'(DEPTH) : word_count;
                        words_written      <= '0;
                        aborted            <= 1'b0;
                        lane               <= '0;
                        last_q             <= 1'b0;
                        bus.mem_writedata  <= '0;
                        bus.mem_byteenable <= '0;
                        bus.in_ready       <= 1'b1;
                        busy               <= 1'b1;
                        state              <= PACK;
                    end
                end
                PACK: begin
                    if (abort) begin
                        lane               <= '0;
                        bus.mem_writedata  <= '0;
                        bus.mem_byteenable <= '0;
                        bus.in_ready       <= 1'b0;
                        busy               <= 1'b0;
                        aborted            <= 1'b1;
                        state              <= IDLE;
                    end else if (accept_c) begin
                        bus.mem_writedata[{lane, 3'b000} +: 8] <= bus.in_data;
                        bus.mem_byteenable[lane]                <= 1'b1;
                        if (lane == 2'd3 || bus.in_last) begin
                            bus.in_ready       <= 1'b0;
                            bus.mem_chipselect <= 1'b1;
                            bus.mem_write      <= 1'b1;
                            bus.mem_address    <= base_q + words_written[ADDR_W-1:0];
                            last_q             <= bus.in_last;
                            state              <= WRITE;
                        end else begin
                            lane <= lane + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    // The write strobe is already on the bus this cycle, so abort cannot cancel it.
                    bus.mem_chipselect <= 1'b0;
                    bus.mem_write      <= 1'b0;
                    bus.mem_writedata  <= '0;
                    bus.mem_byteenable <= '0;
                    words_written      <= ww_next_c;
                    lane               <= '0;
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (ww_next_c == count_q || last_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus.in_ready <= 1'b1;
                        state        <= PACK;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_softproc_mem_stream_loader.sv
// Directed bench: a byte-list model predicts every memory write, a
// negedge monitor checks each write and the bus invariants every cycle.
module tb_softproc_mem_stream_loader;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy, done, aborted;
    logic [ADDR_W:0]   words_written;

    softproc_mem_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

    softproc_mem_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .words_written (words_written),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    wr_t        exp_q[$];
    int         wr_cyc[$];
    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         d0;
    logic [7:0] bytes_a[64];
    bit         last_a[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected writes: chop bytes into words of up to 4, a word closes early on last.
    function automatic void build_model(input logic [ADDR_W-1:0] base, input int cnt, input int nb);
        int i = 0;
        int w = 0;
        int n = (cnt == 0) ? DEPTH : cnt;
        int lane;
        logic [31:0] d;
        logic [3:0] be;
        bit l;
        while (i < nb && w < n) begin
            d = '0; be = '0; lane = 0; l = 1'b0;
            while (lane < 4 && i < nb && !l) begin
                d[8*lane +: 8] = bytes_a[i];
                be[lane] = 1'b1;
                l = last_a[i];
                i++;
                lane++;
            end
            if (lane == 4 || l) begin
                exp_q.push_back('{addr: ADDR_W'(int'(base) + w), data: d, be: be});
                w++;
            end
            if (l) break;
        end
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every write must be the next predicted one.
    always @(negedge clk) begin
        wr_t e;
        if (reset_n) begin
            if (bus.mem_write) begin
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.mem_address, bus.mem_writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", 64'({bus.mem_address, bus.mem_writedata, bus.mem_byteenable, bus.mem_chipselect}),
                        64'({e.addr, e.data, e.be, 1'b1}));
                end
            end
            if (bus.mem_chipselect !== bus.mem_write || (bus.in_ready && !busy)) begin
                tests++;
                fails++;
                $display("FAIL bus_invariant: got cs %b wr %b rdy %b busy %b expected cs==wr, rdy only when busy",
                         bus.mem_chipselect, bus.mem_write, bus.in_ready, busy);
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c, input bit with_abort);
        @(negedge clk);
        start = 1'b1; abort = with_abort; base_addr = b; word_count = c;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
    endtask

    task automatic drive_stream(input int nb, input bit toggle, input int restart_at);
        int i = 0;
        bit acc;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (i >= nb) break;
            bus.in_valid = toggle ? (c % 2 == 0) : 1'b1;
            bus.in_data  = bytes_a[i];
            bus.in_last  = last_a[i];
            start        = (c == restart_at);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        chk("stream_timeout", 64'(i), 64'(nb));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy && !done && !bus.mem_write) return;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic clear_bytes();
        for (int k = 0; k < 64; k++) begin
            bytes_a[k] = '0;
            last_a[k]  = 1'b0;
        end
        wr_cyc.delete();
    endtask

    initial begin
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #12;
        chk("reset_mem", 64'({bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.mem_address,
                              bus.mem_byteenable, bus.mem_writedata}), 64'(0));
        chk("reset_status", 64'({busy, done, aborted, words_written, bus.mem_clken}), 64'(1));
        @(negedge clk); reset_n = 1'b1;

        // Two full words from 0x010.
        clear_bytes();
        for (int k = 0; k < 8; k++) bytes_a[k] = 8'(8'h11 * (k + 1));
        build_model(12'h010, 2, 8);
        chk("model_w0", 64'(exp_q[0].data), 64'h44332211);
        chk("model_w1", 64'(exp_q[1].data), 64'h88776655);
        chk("model_a1", 64'(exp_q[1].addr), 64'h011);
        d0 = done_cnt;
        do_start(12'h010, 13'd2, 1'b0);
        drive_stream(8, 1'b0, -1);
        wait_idle();
        chk("t1_done", 64'(done_cnt - d0), 64'(1));
        chk("t1_ww", 64'(words_written), 64'(2));
        chk("t1_pending", 64'(exp_q.size()), 64'(0));
        chk("t1_word_period", 64'(wr_cyc[1] - wr_cyc[0]), 64'(5));
        chk("t1_aborted", 64'(aborted), 64'(0));

        // Address wrap from the top of memory.
        clear_bytes();
        for (int k = 0; k < 12; k++) bytes_a[k] = 8'(8'hA0 + k);
        build_model(12'hFFF, 3, 12);
        chk("model_wrap", 64'(exp_q[1].addr), 64'h000);
        d0 = done_cnt;
        do_start(12'hFFF, 13'd3, 1'b0);
        drive_stream(12, 1'b0, -1);
        wait_idle();
        chk("t2_done", 64'(done_cnt - d0), 64'(1));
        chk("t2_ww", 64'(words_written), 64'(3));
        chk("t2_pending", 64'(exp_q.size()), 64'(0));

        // Partial last word; abort coinciding with start must be ignored.
        clear_bytes();
        bytes_a[0] = 8'hAA; bytes_a[1] = 8'hBB; bytes_a[2] = 8'hCC; bytes_a[3] = 8'hDD;
        bytes_a[4] = 8'hEE; last_a[4] = 1'b1;
        build_model(12'h200, 4, 5);
        chk("model_partial", 64'({exp_q[1].data, exp_q[1].be}), 64'({32'h000000EE, 4'h1}));
        d0 = done_cnt;
        do_start(12'h200, 13'd4, 1'b1);
        @(negedge clk);
        chk("t3_start_wins", 64'({busy, bus.in_ready, aborted}), 64'(3'b110));
        drive_stream(5, 1'b0, -1);
        wait_idle();
        chk("t3_done", 64'(done_cnt - d0), 64'(1));
        chk("t3_ww", 64'(words_written), 64'(2));
        chk("t3_pending", 64'(exp_q.size()), 64'(0));

        // count 0 means full depth; abort after two words and one byte.
        clear_bytes();
        for (int k = 0; k < 9; k++) bytes_a[k] = 8'(k * 3 + 1);
        build_model(12'h300, 0, 9);
        chk("model_abort_len", 64'(exp_q.size()), 64'(2));
        d0 = done_cnt;
        do_start(12'h300, 13'd0, 1'b0);
        drive_stream(9, 1'b0, -1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("t4_after_abort", 64'({busy, bus.in_ready, aborted}), 64'(3'b001));
        repeat (5) @(negedge clk);
        chk("t4_no_done", 64'(done_cnt - d0), 64'(0));
        chk("t4_ww", 64'(words_written), 64'(2));
        chk("t4_pending", 64'(exp_q.size()), 64'(0));

        // Restart during PACK is ignored; stalling valid must not alter writes.
        clear_bytes();
        for (int k = 0; k < 8; k++) bytes_a[k] = 8'(8'h50 + k);
        build_model(12'h100, 2, 8);
        d0 = done_cnt;
        do_start(12'h100, 13'd2, 1'b0);
        base_addr = 12'h3FF; word_count = 13'd1;
        drive_stream(8, 1'b1, 3);
        wait_idle();
        chk("t5_done", 64'(done_cnt - d0), 64'(1));
        chk("t5_ww", 64'(words_written), 64'(2));
        chk("t5_pending", 64'(exp_q.size()), 64'(0));

        // Reset during the first write.
        clear_bytes();
        for (int k = 0; k < 4; k++) bytes_a[k] = 8'(8'hC0 + k);
        build_model(12'h020, 3, 4);
        d0 = done_cnt;
        do_start(12'h020, 13'd3, 1'b0);
        drive_stream(4, 1'b0, -1);
        chk("t6_in_write", 64'(bus.mem_write), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("t6_reset_mem", 64'({bus.in_ready, bus.mem_chipselect, bus.mem_write, bus.mem_address,
                                 bus.mem_byteenable, bus.mem_writedata}), 64'(0));
        chk("t6_reset_status", 64'({busy, done, aborted, words_written, bus.mem_clken}), 64'(1));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        repeat (12) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t6_idle", 64'({busy, bus.in_ready, aborted, words_written}), 64'(0));
        chk("t6_no_done", 64'(done_cnt - d0), 64'(0));
        chk("t6_pending", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
